mem_xfer_engine: RTL
====================

MEM_XFER_ENGINE -- requirements
Module: mem_xfer_engine

Interface
REQ-001 Parameter WIDTH, default 8, data width of both memories.
REQ-002 Parameter DEPTH, default 8, source memory (memA) entries; power of two, >= 2; destination memory (memB) has DEPTH/2 entries.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new load+transfer job; sampled only in IDLE.
REQ-006 mode  input  2  operation select, latched on start acceptance: 0 COPY, 1 ADD, 2 SUB, 3 ALT.
REQ-007 datain_valid  input  1  dataina carries a word to load.
REQ-008 dataina  input  WIDTH  load data for memA.
REQ-009 rd_addr  input  log2(DEPTH/2), min 1  memB readback address.
REQ-010 rd_data  output  WIDTH  registered memB readback data.
REQ-011 ready  output  1  high in LOAD; word accepted when ready && datain_valid.
REQ-012 busy  output  1  high in LOAD, XFER and DONE.
REQ-013 done  output  1  one-cycle pulse at job completion.
REQ-014 ovf  output  1  sticky arithmetic overflow/borrow flag for the current job.

Function
REQ-015 FSM states IDLE, LOAD, XFER, DONE; IDLE -> LOAD on start; LOAD -> XFER after the DEPTH-th accepted word; XFER -> DONE after last memB write; DONE -> IDLE unconditionally after one cycle.
REQ-016 Start acceptance: latch mode, clear write pointer, transfer index and ovf; start outside IDLE ignored.
REQ-017 LOAD: each accepted word written to memA[wptr], wptr increments; cycles with datain_valid low stall without limit; datain_valid outside LOAD ignored.
REQ-018 XFER: one memB entry per cycle, index i = 0 .. DEPTH/2-1, a = memA[2i], b = memA[2i+1]; XFER lasts exactly DEPTH/2 cycles.
REQ-019 COPY: memB[i] = a.
REQ-020 ADD: memB[i] = (a + b) mod 2^WIDTH; carry out sets ovf.
REQ-021 SUB: memB[i] = (a - b) mod 2^WIDTH; a < b (unsigned borrow) sets ovf.
REQ-022 ALT: even i uses ADD, odd i uses SUB, with the same ovf rules.
REQ-023 ovf sticky from first overflow until next start acceptance or reset; COPY never sets ovf.
REQ-024 done high exactly in DONE state; busy low only in IDLE; ready high only in LOAD.
REQ-025 rd_data <= memB[rd_addr] every cycle (one-cycle latency) in every state; read of the entry being written that cycle returns the old value.
REQ-026 memB contents persist after DONE until overwritten by a later job or reset.
REQ-027 Latency: last accepted load word at edge N -> done high in cycle N+DEPTH/2+1.

Reset
REQ-028 reset low asynchronously forces: state IDLE, pointers 0, mode 0, ready 0, busy 0, done 0, ovf 0, rd_data 0, all memA and memB entries 0.
REQ-029 reset asserted mid-LOAD or mid-XFER aborts the job; no partial results retained; after release the block waits in IDLE for start.

Verification
REQ-030 ADD: start, mode=1, load 4,2,8,19,31,29,22,30 back-to-back -> after 4 XFER cycles memB = 6,27,60,52, ovf=0, single done pulse, 13 cycles from start to done.
REQ-031 SUB/ALT: same data, mode=2 -> memB = 2,245,2,248, ovf=1; mode=3 -> memB = 6,245,60,248, ovf=1.
REQ-032 COPY with gaps: mode=0, same data with datain_valid low every other cycle -> memB = 4,8,31,22, ovf=0, no writes on invalid cycles, ready high throughout LOAD.
REQ-033 Control abuse: start pulsed during LOAD/XFER and datain_valid in IDLE -> no effect on state, memA or mode; following job's ovf cleared at start.
REQ-034 Reset: reset low after 5 loaded words, release, rerun ADD job -> all outputs 0 during reset, memB reads 0 before rerun, rerun yields 6,27,60,52.
REQ-035 Parameters: WIDTH=16, DEPTH=4, ADD of 65535,1,100,200 -> memB = 0,300, ovf=1.

Source files
------------

// File: rtl/mem_xfer_engine.sv
// mem_xfer_engine: loads DEPTH words into a source memory (memA), then folds
// adjacent pairs into a half-size destination memory (memB) using a latched
// COPY/ADD/SUB/ALT operation. memB is readable at any time through a
// registered read port.
module mem_xfer_engine #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int BW    = (DEPTH > 2) ? $clog2(DEPTH / 2) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             datain_valid,
    input  logic [WIDTH-1:0] dataina,
    input  logic [BW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_COPY = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_ALT  = 2'd3
    } op_t;

    localparam logic [AW-1:0] LAST_WPTR = AW'(DEPTH - 1);
    localparam logic [BW-1:0] LAST_IDX  = BW'(DEPTH / 2 - 1);

    state_t           state_q;
    op_t              mode_q;
    logic [AW-1:0]    wptr_q;
    logic [BW-1:0]    idx_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [WIDTH-1:0] rd_data_q;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH/2];

    logic [AW-1:0]    a_addr;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   diff_d;
    logic [WIDTH-1:0] result_d;
    logic             ovf_hit_d;

    // Pair operands for the current transfer index and the selected operation.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        a_addr    = AW'({idx_q, 1'b0});
        b_addr    = a_addr | AW'(1);
        op_a      = mem_a_q[a_addr];
        op_b      = mem_a_q[b_addr];
        sum_d     = {1'b0, op_a} + {1'b0, op_b};
        diff_d    = {1'b0, op_a} - {1'b0, op_b};
        result_d  = op_a;
        ovf_hit_d = 1'b0;
        case (mode_q)
            OP_ADD: begin
                result_d  = sum_d[WIDTH-1:0];
                ovf_hit_d = sum_d[WIDTH];
            end
            OP_SUB: begin
                result_d  = diff_d[WIDTH-1:0];
                ovf_hit_d = diff_d[WIDTH];
            end
            OP_ALT: begin
                if (!idx_q[0]) begin
                    result_d  = sum_d[WIDTH-1:0];
                    ovf_hit_d = sum_d[WIDTH];
                end else begin
                    result_d  = diff_d[WIDTH-1:0];
                    ovf_hit_d = diff_d[WIDTH];
                end
            end
            default: begin
                result_d  = op_a;
                ovf_hit_d = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= OP_COPY;
            wptr_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_LOAD;
                        mode_q  <= op_t'(mode);
                        wptr_q  <= '0;
                        idx_q   <= '0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (datain_valid) begin
                        wptr_q <= wptr_q + AW'(1);
                        if (wptr_q == LAST_WPTR) begin
                            state_q <= S_XFER;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_XFER: begin
                    idx_q <= idx_q + BW'(1);
                    if (ovf_hit_d) begin
                        ovf_q <= 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Source memory: written only by accepted words while loading.
    // NOTE: both memories are flop arrays cleared by reset, so an aborted job
    // leaves no partial data behind; this cannot map onto an SRAM macro.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_a_q[k] <= '0;
            end
        end else if (state_q == S_LOAD && datain_valid) begin
            mem_a_q[wptr_q] <= dataina;
        end
    end

    // Destination memory write during transfer plus the registered read port.
    // NOTE: non-blocking updates mean a read of the entry being written in the
    // same cycle returns its previous contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH / 2; k++) begin
                mem_b_q[k] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (state_q == S_XFER) begin
                mem_b_q[idx_q] <= result_d;
            end
            rd_data_q <= mem_b_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule
